// File: rtl/master_bus_pkg.sv
// rtl/master_bus_pkg.sv - shared master bus instruction codes and FSM state encodings
package master_bus_pkg;

    localparam logic [1:0] INSTR_READ = 2'b11;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_HANDSHAKE = 3'd1;
    localparam logic [2:0] ST_RECEIVE   = 3'd2;
    localparam logic [2:0] ST_DONE      = 3'd3;
    localparam logic [2:0] ST_ERROR     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_HANDSHAKE = ST_HANDSHAKE,
        S_RECEIVE   = ST_RECEIVE,
        S_DONE      = ST_DONE,
        S_ERROR     = ST_ERROR
    } rx_state_t;

endpackage

// File: rtl/master_rx_burst_if.sv
// rtl/master_rx_burst_if.sv - control, slave serial link and consumer word stream of the burst reader
interface master_rx_burst_if #(
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) ();
    logic [1:0]           instruction;
    logic [BURST_LEN-1:0] burst_num;
    logic                 slave_valid;
    logic                 rx_data;
    logic                 master_ready;
    logic [DATA_LEN-1:0]  word_data;
    logic                 word_valid;
    logic                 word_ready;
    logic                 rx_done;
    logic                 rx_error;
    logic                 busy;

    modport master (
        input  instruction, burst_num, slave_valid, rx_data, word_ready,
        output master_ready, word_data, word_valid, rx_done, rx_error, busy
    );

    modport slave (
        output instruction, burst_num, slave_valid, rx_data, word_ready,
        input  master_ready, word_data, word_valid, rx_done, rx_error, busy
    );
endinterface

// File: rtl/rx_word_fifo.sv
// rtl/rx_word_fifo.sv - synchronous word FIFO with count/full/empty; head reads as zero when empty
module rx_word_fifo #(
    parameter int DATA_LEN   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [DATA_LEN-1:0]           push_data,
    input  logic                          pop,
    output logic [DATA_LEN-1:0]           pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/master_rx_burst.sv
// rtl/master_rx_burst.sv - burst serial read master: handshake per word, deserialise, buffer in FIFO
module master_rx_burst
    import master_bus_pkg::*;
#(
    parameter int DATA_LEN   = 8,
    parameter int BURST_LEN  = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    master_rx_burst_if.master  bus
);
    localparam int BIT_W = $clog2(DATA_LEN);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    rx_state_t            state;
    logic [BURST_LEN-1:0] burst_len_q;
    logic [BURST_LEN-1:0] word_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [DATA_LEN-1:0]  shreg;
    logic [DATA_LEN-1:0]  word_next;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 last_bit;
    logic                 handshake;

    assign word_next = (MSB_FIRST != 0) ? {shreg[DATA_LEN-2:0], bus.rx_data}
                                        : {bus.rx_data, shreg[DATA_LEN-1:1]};
    assign last_bit  = (state == S_RECEIVE) && (bit_cnt == BIT_W'(DATA_LEN - 1));

    // Nothing is in flight while waiting for a handshake, so only the stored count matters.
    assign bus.master_ready = (state == S_HANDSHAKE) && (fifo_count < CW'(FIFO_DEPTH));
    assign handshake        = bus.master_ready && bus.slave_valid;
    assign bus.word_valid   = !fifo_empty;
    assign bus.rx_done      = (state == S_DONE);
    assign bus.rx_error     = (state == S_ERROR);
    assign bus.busy         = (state != S_IDLE);

    rx_word_fifo #(
        .DATA_LEN   (DATA_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (last_bit && !fifo_full),
        .push_data (word_next),
        .pop       (bus.word_ready),
        .pop_data  (bus.word_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            burst_len_q <= '0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            shreg       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instruction == INSTR_READ) begin
                        burst_len_q <= bus.burst_num;
                        word_cnt    <= '0;
                        to_cnt      <= '0;
                        state       <= S_HANDSHAKE;
                    end
                end
                S_HANDSHAKE: begin
                    if (handshake) begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        state   <= S_RECEIVE;
                    end else if (bus.master_ready) begin
                        // A stalled (full) FIFO holds master_ready low and so never times out.
                        if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                            state <= S_ERROR;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                S_RECEIVE: begin
                    shreg <= word_next;
                    if (last_bit) begin
                        if (word_cnt == burst_len_q) begin
                            state <= S_DONE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            state    <= S_HANDSHAKE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_master_rx_burst.sv
// tb/tb_master_rx_burst.sv - scoreboard bench for master_rx_burst (LSB-first/timeout unit and MSB-first/narrow-counter unit)
module tb_master_rx_burst;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int done_a;
    int err_a;
    int done_b;
    int err_b;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    master_rx_burst_if #(.DATA_LEN(8), .BURST_LEN(12)) a ();
    master_rx_burst_if #(.DATA_LEN(8), .BURST_LEN(3))  b ();

    master_rx_burst #(
        .DATA_LEN(8), .BURST_LEN(12), .FIFO_DEPTH(4), .MSB_FIRST(0), .TIMEOUT(16)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a)
    );

    master_rx_burst #(
        .DATA_LEN(8), .BURST_LEN(3), .FIFO_DEPTH(4), .MSB_FIRST(1), .TIMEOUT(255)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    always #5 clk = ~clk;

    // Scoreboard: every consumer pop is compared against the oldest expected word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (a.rx_done)  done_a++;
            if (a.rx_error) err_a++;
            if (b.rx_done)  done_b++;
            if (b.rx_error) err_b++;
            if (a.word_valid && a.word_ready) begin
                n_checks++;
                if (exp_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_a: unexpected word %h, scoreboard empty", a.word_data);
                end else if (a.word_data !== exp_a[0]) begin
                    n_fail++;
                    $display("FAIL pop_a: got %h required %h", a.word_data, exp_a[0]);
                    void'(exp_a.pop_front());
                end else begin
                    void'(exp_a.pop_front());
                end
            end
            if (b.word_valid && b.word_ready) begin
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_b: unexpected word %h, scoreboard empty", b.word_data);
                end else if (b.word_data !== exp_b[0]) begin
                    n_fail++;
                    $display("FAIL pop_b: got %h required %h", b.word_data, exp_b[0]);
                    void'(exp_b.pop_front());
                end else begin
                    void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic [11:0] n);
        a.burst_num   = n;
        a.instruction = 2'b11;
        tick();
        a.instruction = 2'b00;
    endtask

    task automatic start_b(input logic [2:0] n);
        b.burst_num   = n;
        b.instruction = 2'b11;
        tick();
        b.instruction = 2'b00;
    endtask

    task automatic send_a(input logic [7:0] w);
        int guard;
        exp_a.push_back(w);
        a.slave_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!a.master_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (a.master_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_a: master_ready=%b required 1 within 200 cycles", a.master_ready);
        end
        tick();
        a.slave_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a.rx_data = w[i];
            tick();
        end
        a.rx_data = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w);
        int guard;
        exp_b.push_back(w);
        b.slave_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!b.master_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (b.master_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_b: master_ready=%b required 1 within 200 cycles", b.master_ready);
        end
        tick();
        b.slave_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b.rx_data = w[7-i];
            tick();
        end
        b.rx_data = 1'b0;
    endtask

    task automatic drain_a();
        a.word_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!a.word_valid) break;
        end
        n_checks++;
        if (exp_a.size() != 0 || a.word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_a: %0d words outstanding, word_valid=%b required 0/0", exp_a.size(), a.word_valid);
        end
        tick();
    endtask

    task automatic drain_b();
        b.word_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!b.word_valid) break;
        end
        n_checks++;
        if (exp_b.size() != 0 || b.word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_b: %0d words outstanding, word_valid=%b required 0/0", exp_b.size(), b.word_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a.master_ready, a.word_valid, a.rx_done, a.rx_error, a.busy, a.word_data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_a: ready/valid/done/err/busy/data=%b%b%b%b%b/%h required all 0",
                     a.master_ready, a.word_valid, a.rx_done, a.rx_error, a.busy, a.word_data);
        end
        n_checks++;
        if ({b.master_ready, b.word_valid, b.rx_done, b.rx_error, b.busy, b.word_data} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_b: ready/valid/done/err/busy/data=%b%b%b%b%b/%h required all 0",
                     b.master_ready, b.word_valid, b.rx_done, b.rx_error, b.busy, b.word_data);
        end
        reset_n = 1'b1;
        tick();
        a.instruction = 2'b01;
        tick();
        a.instruction = 2'b00;
        n_checks++;
        if (a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL other_instr: busy=%b required 0", a.busy);
        end
    endtask

    task automatic test_single_word();
        a.word_ready = 1'b0;
        start_a(12'd0);
        send_a(8'hA5);
        @(negedge clk);
        n_checks++;
        if (a.rx_done !== 1'b1 || a.word_valid !== 1'b1 || a.word_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_word: done=%b valid=%b data=%h required 1 1 a5", a.rx_done, a.word_valid, a.word_data);
        end
        tick();
        n_checks++;
        if (a.rx_done !== 1'b0 || a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: done=%b busy=%b required 0 0", a.rx_done, a.busy);
        end
        drain_a();
        repeat (3) tick();
        n_checks++;
        if (a.word_valid !== 1'b0 || a.word_data !== 8'h00) begin
            n_fail++;
            $display("FAIL pop_empty: valid=%b data=%h required 0 00", a.word_valid, a.word_data);
        end
    endtask

    task automatic test_burst();
        int d0;
        d0 = done_a;
        a.word_ready = 1'b1;
        start_a(12'd3);
        a.instruction = 2'b11;
        send_a(8'h01);
        send_a(8'h02);
        send_a(8'h03);
        a.instruction = 2'b00;
        send_a(8'h04);
        @(negedge clk);
        n_checks++;
        if (a.rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_done: rx_done=%b required 1", a.rx_done);
        end
        tick();
        drain_a();
        n_checks++;
        if (done_a != d0 + 1 || a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_pulses: rx_done pulses=%0d busy=%b required 1 0", done_a - d0, a.busy);
        end
    endtask

    task automatic test_back_to_back();
        int stall_bad;
        a.word_ready = 1'b0;
        start_a(12'd5);
        for (int w = 1; w <= 4; w++) send_a(8'(w));
        a.slave_valid = 1'b1;
        stall_bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (a.master_ready !== 1'b0 || a.rx_error !== 1'b0) stall_bad++;
        end
        n_checks++;
        if (stall_bad != 0 || a.busy !== 1'b1 || a.word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure: bad stall cycles=%0d busy=%b valid=%b required 0 1 1", stall_bad, a.busy, a.word_valid);
        end
        tick();
        a.word_ready = 1'b1;
        send_a(8'h05);
        send_a(8'h06);
        @(negedge clk);
        n_checks++;
        if (a.rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_done: rx_done=%b required 1", a.rx_done);
        end
        tick();
        drain_a();
    endtask

    task automatic test_timeout();
        int n;
        int e0;
        e0 = err_a;
        a.word_ready = 1'b0;
        start_a(12'd3);
        send_a(8'h11);
        send_a(8'h22);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a.rx_error) break;
            n++;
        end
        n_checks++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL timeout_cycles: rx_error after %0d handshake cycles required 16", n);
        end
        tick();
        n_checks++;
        if (err_a != e0 + 1 || a.busy !== 1'b0 || a.word_valid !== 1'b1 || a.rx_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: pulses=%0d busy=%b valid=%b err=%b required 1 0 1 0",
                     err_a - e0, a.busy, a.word_valid, a.rx_error);
        end
        drain_a();
    endtask

    task automatic test_msb_first();
        int d0;
        b.word_ready = 1'b0;
        start_b(3'd0);
        send_b(8'hC0);
        @(negedge clk);
        n_checks++;
        if (b.rx_done !== 1'b1 || b.word_data !== 8'hC0) begin
            n_fail++;
            $display("FAIL msb_first: done=%b data=%h required 1 c0", b.rx_done, b.word_data);
        end
        tick();
        drain_b();
        d0 = done_b;
        start_b(3'd7);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                n_checks++;
                if (done_b != d0 || b.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL max_burst_early: pulses=%0d busy=%b before last word required 0 1", done_b - d0, b.busy);
                end
            end
            send_b(8'($urandom_range(0, 255)));
        end
        @(negedge clk);
        n_checks++;
        if (b.rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL max_burst_done: rx_done=%b required 1", b.rx_done);
        end
        tick();
        drain_b();
    endtask

    task automatic test_reset_mid_burst();
        int d0;
        int e0;
        a.word_ready = 1'b0;
        start_a(12'd2);
        send_a(8'h3C);
        a.slave_valid = 1'b1;
        @(negedge clk);
        tick();
        a.slave_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a.rx_data = 1'b1;
            tick();
        end
        d0 = done_a;
        e0 = err_a;
        reset_n = 1'b0;
        exp_a.delete();
        #1;
        n_checks++;
        if ({a.busy, a.word_valid, a.master_ready, a.rx_done, a.rx_error} !== 5'b0 || a.word_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: busy/valid/ready/done/err=%b%b%b%b%b data=%h required 0 00",
                     a.busy, a.word_valid, a.master_ready, a.rx_done, a.rx_error, a.word_data);
        end
        a.rx_data = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (done_a != d0 || err_a != e0) begin
            n_fail++;
            $display("FAIL mid_reset_pulses: done=%0d err=%0d required 0 0", done_a - d0, err_a - e0);
        end
        start_a(12'd0);
        send_a(8'h5A);
        @(negedge clk);
        n_checks++;
        if (a.rx_done !== 1'b1 || a.word_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL after_reset: done=%b data=%h required 1 5a", a.rx_done, a.word_data);
        end
        tick();
        drain_a();
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        n_checks = 0;
        n_fail = 0;
        done_a = 0;
        err_a = 0;
        done_b = 0;
        err_b = 0;
        a.instruction = 2'b00; a.burst_num = '0; a.slave_valid = 1'b0; a.rx_data = 1'b0; a.word_ready = 1'b0;
        b.instruction = 2'b00; b.burst_num = '0; b.slave_valid = 1'b0; b.rx_data = 1'b0; b.word_ready = 1'b0;

        test_reset();
        test_single_word();
        test_burst();
        test_back_to_back();
        test_timeout();
        test_msb_first();
        test_reset_mid_burst();

        n_checks++;
        if (err_b != 0) begin
            n_fail++;
            $display("FAIL unit_b_errors: rx_error pulses=%0d required 0", err_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
